dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage
//  (EX_MEM address/store data, MemRead/MemWrite) and a slow block-wide data memory.
//  Returns load data and holds stall_o high on a miss while victim write-back and refill
//  run. While stall_o is high the pipeline freezes PC and all pipeline registers.
// PARAMETERS
//  LINES       32   number of cache lines (power of 2); index = addr[9:5] at default
//  BLOCK_BITS  256  line width (8 x 32-bit words); offset = addr[4:0], word = addr[4:2]
//  ADDR_W      32   byte address width; tag = addr[ADDR_W-1:10] at default (22 bits)
// PORTS
//  clk_i        in   1           clock, rising edge
//  rst_i        in   1           asynchronous reset, active-high
//  cpu_addr_i   in   ADDR_W      byte address (word-aligned) from EX_MEM ALU result
//  cpu_data_i   in   32          store data
//  cpu_read_i   in   1           load request
//  cpu_write_i  in   1           store request
//  cpu_data_o   out  32          load data, valid when cpu_read_i & !stall_o
//  stall_o      out  1           freeze pipeline
//  mem_addr_o   out  ADDR_W      block-aligned memory address (bits [4:0] = 0)
//  mem_data_o   out  BLOCK_BITS  victim line for write-back
//  mem_enable_o out  1           memory request, held until ack
//  mem_write_o  out  1           1 = write-back, 0 = refill read
//  mem_data_i   in   BLOCK_BITS  refill line, valid with mem_ack_i
//  mem_ack_i    in   1           one-cycle completion pulse
// BEHAVIOUR
//  Reset (async): all valid/dirty bits 0, state IDLE, mem_enable_o=0, mem_write_o=0,
//   mem_addr_o=0, mem_data_o=0, cpu_data_o=0; stall_o = combinational miss only.
//  hit = valid[idx] & tag[idx]==addr tag. req = cpu_read_i | cpu_write_i.
//  stall_o = req & (!hit | state!=IDLE), combinational, same cycle as request.
//  Read hit: cpu_data_o = selected word of line, combinational, 0-cycle latency.
//  Write hit: at clock edge write cpu_data_i into word, set dirty[idx]; no stall.
//  cpu_read_i & cpu_write_i together: treated as write; cpu_data_o don't-care.
//  Request signals held stable by pipeline while stall_o=1; no request -> no action.
//  FSM:
//   IDLE:      req & miss & valid & dirty -> WRITEBACK; req & miss otherwise -> ALLOCATE.
//   WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,idx,5'b0},
//              mem_data_o=victim line; on mem_ack_i -> ALLOCATE.
//   ALLOCATE:  mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,idx,5'b0};
//              on mem_ack_i capture mem_data_i, set tag, valid=1, dirty=0 -> REFILLED.
//   REFILLED:  mem_enable_o=0; request now hits; store merges and sets dirty -> IDLE.
//  Drop mem_enable_o the cycle after ack; ack with mem_enable_o=0 is ignored.
//  Miss latency: clean = ack delay + 2 cycles; dirty adds one full write-back.
//  Invalid line never written back regardless of dirty.
//  Reset mid-miss: abort at once, outstanding request dropped, partial line discarded.
// STRUCTURE
//  Package dcache_pkg: state enum {IDLE,WRITEBACK,ALLOCATE,REFILLED}, TAG_W/IDX_W/
//   OFF_W localparams derived from parameters, address-field slicing functions.
//  Sub-module dcache_sram: tag+valid+dirty array and data array, async read,
//   sync write with 32-bit word-enable or full-line write; controller owns FSM only.
// TESTING
//  Cold load addr 0x0000_0400: stall_o=1, ALLOCATE read of 0x400, ack after 10 cyc
//   -> stall drops, cpu_data_o = refill word 0; next load 0x404 hits, no stall.
//  Store 0xDEADBEEF to 0x400 on hit -> no stall, dirty[0]=1; load 0x400 -> 0xDEADBEEF.
//  Load 0x0000_0800 (same idx 0, new tag) after dirty store -> WRITEBACK to 0x400 with
//   word0=0xDEADBEEF, then ALLOCATE 0x800, total stall = 2 acks + 2 cycles.
//  Store miss to clean line 0x0000_0C20 -> no write-back, refill, merged word at 0x0C20,
//   dirty[1]=1, other 7 words equal refill data.
//  rst_i asserted in ALLOCATE before ack -> mem_enable_o=0 at once, all lines invalid,
//   late ack ignored; replayed load misses again.
//  Simultaneous read+write hit 0x404 value 0x1234 -> treated as store, no stall.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILLED} state_e;

    localparam int DC_LINES      = 32;
    localparam int DC_BLOCK_BITS = 256;
    localparam int DC_ADDR_W     = 32;
    localparam int DC_IDX_W      = $clog2(DC_LINES);
    localparam int DC_OFF_W      = $clog2(DC_BLOCK_BITS / 8);
    localparam int DC_TAG_W      = DC_ADDR_W - DC_IDX_W - DC_OFF_W;

    // Extract a [lsb +: width] field; callers cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                               input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data arrays: async read, word write (sets dirty) or full-line fill.
module dcache_sram #(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256,
    parameter int TAG_W      = 22,
    parameter int IDX_W      = $clog2(LINES),
    parameter int WSEL_W     = $clog2(BLOCK_BITS / 32)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [BLOCK_BITS-1:0] line_o,
    input  logic                  word_we_i,
    input  logic [WSEL_W-1:0]     wsel_i,
    input  logic [31:0]           word_i,
    input  logic                  fill_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [BLOCK_BITS-1:0] fill_line_i
);

    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign line_o  = data_q[idx_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][32*wsel_i +: 32] <= word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// L1 data cache controller: hit path, miss FSM driving write-back and refill to memory.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = DC_LINES,
    parameter int BLOCK_BITS = DC_BLOCK_BITS,
    parameter int ADDR_W     = DC_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    input  logic                  cpu_read_i,
    input  logic                  cpu_write_i,
    output logic [31:0]           cpu_data_o,
    output logic                  stall_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
    localparam int WSEL_W = $clog2(BLOCK_BITS / 32);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WSEL_W-1:0]     wsel;
    logic [TAG_W-1:0]      line_tag;
    logic                  line_valid, line_dirty;
    logic [BLOCK_BITS-1:0] line_data;
    logic                  hit, req, word_we, fill;

    state_e                state_q;
    logic                  mem_enable_q, mem_write_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [BLOCK_BITS-1:0] mem_data_q;

    assign idx  = IDX_W'(addr_field(64'(cpu_addr_i), OFF_W, IDX_W));
    assign tag  = TAG_W'(addr_field(64'(cpu_addr_i), OFF_W + IDX_W, TAG_W));
    assign wsel = WSEL_W'(addr_field(64'(cpu_addr_i), 2, WSEL_W));

    assign hit     = line_valid & (line_tag == tag);
    assign req     = cpu_read_i | cpu_write_i;
    assign stall_o = req & (~hit | (state_q != IDLE));
    // REFILLED also accepts the store so the merged word lands before stall drops.
    assign word_we = cpu_write_i & hit & ((state_q == IDLE) | (state_q == REFILLED));
    assign fill    = (state_q == ALLOCATE) & mem_ack_i;

    assign cpu_data_o = (cpu_read_i & ~cpu_write_i & hit) ? line_data[32*wsel +: 32] : 32'h0;

    dcache_sram #(
        .LINES      (LINES),
        .BLOCK_BITS (BLOCK_BITS),
        .TAG_W      (TAG_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx),
        .tag_o       (line_tag),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .line_o      (line_data),
        .word_we_i   (word_we),
        .wsel_i      (wsel),
        .word_i      (cpu_data_i),
        .fill_i      (fill),
        .fill_tag_i  (tag),
        .fill_line_i (mem_data_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req & ~hit) begin
                    mem_enable_q <= 1'b1;
                    if (line_valid & line_dirty) begin
                        state_q     <= WRITEBACK;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {line_tag, idx, {OFF_W{1'b0}}};
                        mem_data_q  <= line_data;
                    end else begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {tag, idx, {OFF_W{1'b0}}};
                    end
                end
                WRITEBACK: if (mem_ack_i) begin
                    state_q     <= ALLOCATE;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= {tag, idx, {OFF_W{1'b0}}};
                end
                ALLOCATE: if (mem_ack_i) begin
                    state_q      <= REFILLED;
                    mem_enable_q <= 1'b0;
                end
                REFILLED: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency block memory model.
module tb_dcache_ctrl;

    localparam int DELAY = 10;
    // Clean miss: issue cycle + DELAY cycles of enable + ack cycle + REFILLED cycle.
    localparam int CLEAN_MISS = DELAY + 3;
    // Dirty miss adds the write-back: DELAY cycles of enable plus its ack cycle.
    localparam int DIRTY_MISS = 2 * DELAY + 4;

    logic         clk, rst;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_rd, cpu_wr, stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack_q, ack_force;

    int           cnt;
    int           wb_cnt;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    int           total, bad;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_addr_i   (cpu_addr),
        .cpu_data_i   (cpu_wdata),
        .cpu_read_i   (cpu_rd),
        .cpu_write_i  (cpu_wr),
        .cpu_data_o   (cpu_rdata),
        .stall_o      (stall),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_we),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack_q | ack_force)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at byte address a reads as 0x5A5A_<a[15:0]>.
    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] r;
        for (int w = 0; w < 8; w++)
            r[w*32 +: 32] = 32'h5A5A_0000 | ((a + 32'(w * 4)) & 32'h0000_FFFF);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 0;
            mem_ack_q <= 1'b0;
        end else begin
            mem_ack_q <= 1'b0;
            if (mem_en && !mem_ack_q) begin
                if (cnt == DELAY - 1) begin
                    cnt       <= 0;
                    mem_ack_q <= 1'b1;
                    if (mem_we) begin
                        wb_cnt  <= wb_cnt + 1;
                        wb_addr <= mem_addr;
                        wb_data <= mem_wdata;
                    end else begin
                        mem_rdata <= pat(mem_addr);
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] d);
        cpu_addr  = a;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_wdata = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts clock edges until stall drops; request already driven and stalled.
    task automatic wait_stall(input int already, output int n);
        n = already;
        while (stall === 1'b1 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            bad++;
            $display("FAIL stall_timeout: stall still high after %0d cycles, required drop", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        step();
        total++; if (stall !== 1'b0)      begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (mem_en !== 1'b0)     begin bad++; $display("FAIL rst_en: got %b want 0", mem_en); end
        total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
        total++; if (mem_addr !== 32'h0)  begin bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 256'h0) begin bad++; $display("FAIL rst_mdata: got %h want 0", mem_wdata); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_cold_load();
        int n;
        drive(32'h400, 1'b1, 1'b0, 32'h0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL cold_stall: got %b want 1", stall); end
        step();
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h400) begin
            bad++; $display("FAIL cold_req: en=%b we=%b addr=%h want en=1 we=0 addr=400", mem_en, mem_we, mem_addr);
        end
        wait_stall(1, n);
        total++; if (n != CLEAN_MISS) begin bad++; $display("FAIL cold_latency: got %0d want %0d", n, CLEAN_MISS); end
        total++; if (cpu_rdata !== 32'h5A5A_0400) begin bad++; $display("FAIL cold_data: got %h want 5a5a0400", cpu_rdata); end
        drive(32'h404, 1'b1, 1'b0, 32'h0);
        total++; if (stall !== 1'b0 || cpu_rdata !== 32'h5A5A_0404) begin
            bad++; $display("FAIL hit_404: stall=%b data=%h want 0 5a5a0404", stall, cpu_rdata);
        end
    endtask

    task automatic test_store_hit();
        drive(32'h400, 1'b0, 1'b1, 32'hDEAD_BEEF);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL store_stall: got %b want 0", stall); end
        step();
        drive(32'h400, 1'b1, 1'b0, 32'h0);
        total++; if (stall !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL store_readback: stall=%b data=%h want 0 deadbeef", stall, cpu_rdata);
        end
        drive(32'h404, 1'b1, 1'b1, 32'h0000_1234);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rdwr_stall: got %b want 0", stall); end
        step();
        drive(32'h404, 1'b1, 1'b0, 32'h0);
        total++; if (cpu_rdata !== 32'h0000_1234) begin bad++; $display("FAIL rdwr_data: got %h want 00001234", cpu_rdata); end
    endtask

    task automatic test_dirty_evict();
        int n;
        int wb0;
        wb0 = wb_cnt;
        drive(32'h800, 1'b1, 1'b0, 32'h0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL evict_stall: got %b want 1", stall); end
        step();
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h400) begin
            bad++; $display("FAIL evict_req: en=%b we=%b addr=%h want 1 1 400", mem_en, mem_we, mem_addr);
        end
        wait_stall(1, n);
        total++; if (n != DIRTY_MISS) begin bad++; $display("FAIL evict_latency: got %0d want %0d", n, DIRTY_MISS); end
        total++; if (wb_cnt != wb0 + 1 || wb_addr !== 32'h400) begin
            bad++; $display("FAIL evict_wb: count=%0d addr=%h want %0d 400", wb_cnt, wb_addr, wb0 + 1);
        end
        total++; if (wb_data[31:0] !== 32'hDEAD_BEEF || wb_data[63:32] !== 32'h0000_1234 ||
                     wb_data[255:224] !== 32'h5A5A_041C) begin
            bad++; $display("FAIL evict_wbdata: w0=%h w1=%h w7=%h want deadbeef 00001234 5a5a041c",
                            wb_data[31:0], wb_data[63:32], wb_data[255:224]);
        end
        total++; if (cpu_rdata !== 32'h5A5A_0800) begin bad++; $display("FAIL evict_data: got %h want 5a5a0800", cpu_rdata); end
    endtask

    task automatic test_store_miss();
        int n;
        int wb0;
        wb0 = wb_cnt;
        drive(32'hC20, 1'b0, 1'b1, 32'h1111_2222);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL smiss_stall: got %b want 1", stall); end
        wait_stall(0, n);
        total++; if (n != CLEAN_MISS || wb_cnt != wb0) begin
            bad++; $display("FAIL smiss_latency: cycles=%0d wbs=%0d want %0d %0d", n, wb_cnt - wb0, CLEAN_MISS, 0);
        end
        step();
        drive(32'hC20, 1'b1, 1'b0, 32'h0);
        total++; if (cpu_rdata !== 32'h1111_2222) begin bad++; $display("FAIL smiss_w0: got %h want 11112222", cpu_rdata); end
        drive(32'hC24, 1'b1, 1'b0, 32'h0);
        total++; if (cpu_rdata !== 32'h5A5A_0C24) begin bad++; $display("FAIL smiss_w1: got %h want 5a5a0c24", cpu_rdata); end
        drive(32'hC3C, 1'b1, 1'b0, 32'h0);
        total++; if (cpu_rdata !== 32'h5A5A_0C3C) begin bad++; $display("FAIL smiss_w7: got %h want 5a5a0c3c", cpu_rdata); end
        // Evicting line 1 must write back the merged store.
        drive(32'h1020, 1'b1, 1'b0, 32'h0);
        wait_stall(0, n);
        total++; if (n != DIRTY_MISS || wb_addr !== 32'hC20) begin
            bad++; $display("FAIL smiss_evict: cycles=%0d addr=%h want %0d c20", n, wb_addr, DIRTY_MISS);
        end
        total++; if (wb_data[31:0] !== 32'h1111_2222 || wb_data[255:224] !== 32'h5A5A_0C3C) begin
            bad++; $display("FAIL smiss_wbdata: w0=%h w7=%h want 11112222 5a5a0c3c", wb_data[31:0], wb_data[255:224]);
        end
        total++; if (cpu_rdata !== 32'h5A5A_1020) begin bad++; $display("FAIL smiss_newdata: got %h want 5a5a1020", cpu_rdata); end
    endtask

    task automatic test_reset_mid_miss();
        int n;
        int wb0;
        drive(32'h2000, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h2000) begin
            bad++; $display("FAIL rmid_pre: en=%b addr=%h want 1 2000", mem_en, mem_addr);
        end
        rst = 1'b1;
        #1;
        total++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL rmid_abort: en=%b addr=%h want 0 0", mem_en, mem_addr);
        end
        step();
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        ack_force = 1'b1;
        step();
        ack_force = 1'b0;
        step();
        total++; if (mem_en !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rmid_lateack: en=%b stall=%b want 0 0", mem_en, stall);
        end
        wb0 = wb_cnt;
        drive(32'h1020, 1'b1, 1'b0, 32'h0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rmid_replay: stall=%b want 1", stall); end
        wait_stall(0, n);
        total++; if (n != CLEAN_MISS || wb_cnt != wb0 || cpu_rdata !== 32'h5A5A_1020) begin
            bad++; $display("FAIL rmid_refill: cycles=%0d wbs=%0d data=%h want %0d 0 5a5a1020",
                            n, wb_cnt - wb0, cpu_rdata, CLEAN_MISS);
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        wb_cnt    = 0;
        wb_addr   = '0;
        wb_data   = '0;
        mem_rdata = '0;
        ack_force = 1'b0;
        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        @(negedge clk);
        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_store_miss();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
